// File: rtl/tone_generator.sv
// Square-wave tone generator: notes do..si over three octaves, glitch-free changes at half-period boundaries.
// Optional macro VOLUME_CTRL_EN adds a 2-bit volume port and PWM gating of the speaker output.
module tone_generator #(
    parameter int CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] note_in,
    input  logic [1:0] octave,
`ifdef VOLUME_CTRL_EN
    input  logic [1:0] volume,
`endif
    output logic       speaker,
    output logic       playing,
    output logic [3:0] note_active
);

    localparam int H_DO = CLK_HZ / (2 * 262);
    localparam int H_RE = CLK_HZ / (2 * 294);
    localparam int H_MI = CLK_HZ / (2 * 330);
    localparam int H_FA = CLK_HZ / (2 * 349);
    localparam int H_SO = CLK_HZ / (2 * 392);
    localparam int H_LA = CLK_HZ / (2 * 440);
    localparam int H_SI = CLK_HZ / (2 * 494);

    typedef enum logic {IDLE, PLAY} state_t;

    function automatic logic [19:0] base_half(input logic [3:0] n);
        logic [19:0] h;
        case (n)
            4'd1:    h = 20'(H_DO);
            4'd2:    h = 20'(H_RE);
            4'd3:    h = 20'(H_MI);
            4'd4:    h = 20'(H_FA);
            4'd5:    h = 20'(H_SO);
            4'd6:    h = 20'(H_LA);
            4'd7:    h = 20'(H_SI);
            default: h = 20'd1;
        endcase
        return h;
    endfunction

    // Octave scaling; a zero result (tiny CLK_HZ) is clamped so the wave toggles every cycle.
    function automatic logic [19:0] eff_half(input logic [3:0] n, input logic [1:0] o);
        logic [19:0] b;
        logic [19:0] h;
        b = base_half(n);
        case (o)
            2'd0:    h = b << 1;
            2'd1:    h = b;
            default: h = b >> 1;
        endcase
        if (h == 20'd0) h = 20'd1;
        return h;
    endfunction

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        square_q, square_d;
    logic [3:0]  note_q, note_d;
    logic [1:0]  oct_q, oct_d;
    logic [19:0] half;
    logic        note_valid;

    assign note_valid = (note_in >= 4'd1) && (note_in <= 4'd7);
    assign half       = eff_half(note_q, oct_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        note_d   = note_q;
        oct_d    = oct_q;
        case (state_q)
            IDLE: begin
                cnt_d    = 20'd0;
                square_d = 1'b0;
                if (note_valid) begin
                    state_d  = PLAY;
                    square_d = 1'b1;
                    note_d   = note_in;
                    oct_d    = octave;
                end
            end
            PLAY: begin
                // Inputs are only looked at on the last cycle of a half-period.
                if (cnt_q == half - 20'd1) begin
                    cnt_d = 20'd0;
                    if (note_valid) begin
                        square_d = ~square_q;
                        note_d   = note_in;
                        oct_d    = octave;
                    end else begin
                        state_d  = IDLE;
                        square_d = 1'b0;
                        note_d   = 4'd0;
                        oct_d    = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 20'd0;
            square_q <= 1'b0;
            note_q   <= 4'd0;
            oct_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
            note_q   <= note_d;
            oct_q    <= oct_d;
        end
    end

    assign playing     = (state_q == PLAY);
    assign note_active = note_q;

`ifdef VOLUME_CTRL_EN
    logic [3:0] pwm_q;
    logic       spk_q;
    logic       gate;

    always_comb begin
        case (volume)
            2'd3:    gate = 1'b1;
            2'd2:    gate = (pwm_q < 4'd8);
            2'd1:    gate = (pwm_q < 4'd4);
            default: gate = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 4'd0;
            spk_q <= 1'b0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            spk_q <= square_q & gate;
        end
    end

    assign speaker = spk_q;
`else
    assign speaker = square_q;
`endif

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator at CLK_HZ = 10480 (do H=20, mi H=15, la H=11).
module tb_tone_generator;

    logic       clk;
    logic       rst_n;
    logic [3:0] note_in;
    logic [1:0] octave;
    logic       speaker;
    logic       playing;
    logic [3:0] note_active;
`ifdef VOLUME_CTRL_EN
    logic [1:0] volume;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    tone_generator #(.CLK_HZ(10480)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .note_in     (note_in),
        .octave      (octave),
`ifdef VOLUME_CTRL_EN
        .volume      (volume),
`endif
        .speaker     (speaker),
        .playing     (playing),
        .note_active (note_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts cycles the speaker stays at lvl (n0 already seen); stops on a change or when play ends.
    task automatic count_level(input logic lvl, input int n0, output int n);
        bit done;
        done = 1'b0;
        n = n0;
        for (int i = 0; i < 500 && !done; i++) begin
            tick;
            if (speaker !== lvl || playing !== 1'b1) done = 1'b1;
            else n++;
        end
        if (!done) check("phase_timeout", 32'd1, 32'd0);
    endtask

    int n;
    int hc;

    initial begin
        rst_n   = 1'b0;
        note_in = 4'd0;
        octave  = 2'd0;
`ifdef VOLUME_CTRL_EN
        volume  = 2'd3;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_speaker", speaker, 0);
        check("rst_playing", playing, 0);
        check("rst_note", note_active, 0);

        rst_n = 1'b1; note_in = 4'd1; octave = 2'd1;
        tick;
        check("start_playing", playing, 1);
        check("start_note", note_active, 1);
`ifndef VOLUME_CTRL_EN
        check("start_speaker", speaker, 1);
`else
        tick;
`endif
        count_level(1'b1, 1, n); check("do_high", n, 20);
        count_level(1'b0, 1, n); check("do_low", n, 20);

        note_in = 4'd6; octave = 2'd0;
        count_level(1'b1, 1, n); check("do_to_la_cur", n, 20);
        count_level(1'b0, 1, n); check("la_oct0_low", n, 22);
        check("la_note", note_active, 6);
        count_level(1'b1, 1, n); check("la_oct0_high", n, 22);

        octave = 2'd2;
        count_level(1'b0, 1, n); check("oct2_cur", n, 22);
        count_level(1'b1, 1, n); check("la_oct2_high", n, 5);
        count_level(1'b0, 1, n); check("la_oct2_low", n, 5);

        note_in = 4'd1; octave = 2'd1;
        count_level(1'b1, 1, n); check("back_do_cur", n, 5);
        count_level(1'b0, 1, n); check("back_do_low", n, 20);

        repeat (6) tick;
        note_in = 4'd6;
        count_level(1'b1, 7, n); check("mid_switch_cur", n, 20);
        count_level(1'b0, 1, n); check("mid_switch_next", n, 11);

        repeat (3) tick;
        note_in = 4'd0;
        repeat (3) tick;
        note_in = 4'd6;
        count_level(1'b1, 7, n); check("revert_len", n, 11);
        check("revert_playing", playing, 1);
        count_level(1'b0, 1, n); check("revert_next", n, 11);

        note_in = 4'd0;
        count_level(1'b1, 1, n); check("sil_cur", n, 11);
        check("sil_playing", playing, 0);
        check("sil_note", note_active, 0);
        check("sil_speaker", speaker, 0);

        note_in = 4'd9;
        repeat (4) tick;
        check("idle_code9", playing, 0);

        note_in = 4'd3; octave = 2'd1;
        tick;
        check("restart_playing", playing, 1);
        check("restart_note", note_active, 3);
`ifndef VOLUME_CTRL_EN
        check("restart_speaker", speaker, 1);
`else
        tick;
`endif
        count_level(1'b1, 1, n); check("mi_high", n, 15);

        note_in = 4'd9;
        count_level(1'b0, 1, n); check("sil9_cur", n, 15);
        check("sil9_playing", playing, 0);

        note_in = 4'd1; octave = 2'd1;
        tick;
        repeat (4) tick;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_speaker", speaker, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_note", note_active, 0);
        note_in = 4'd0;
        #1 rst_n = 1'b1;
        tick; tick;
        check("post_rst_idle", playing, 0);
        note_in = 4'd1;
        tick;
        check("post_rst_play", playing, 1);
`ifdef VOLUME_CTRL_EN
        tick;
`endif
        count_level(1'b1, 1, n); check("post_rst_high", n, 20);

`ifdef VOLUME_CTRL_EN
        count_level(1'b0, 1, n); check("vol_pre_low", n, 20);
        volume = 2'd1;
        tick;
        hc = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (speaker === 1'b1) hc++;
        end
        check("vol1_high_of_16", hc, 4);
        volume = 2'd0;
        hc = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (speaker === 1'b1) hc++;
        end
        check("vol0_silent", hc, 0);
        check("vol0_playing", playing, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
